// File: rtl/ring_counter_pkg.sv
// Shared types and default sizes for the adder ring-oscillator measurement block.
package ring_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_DONE
  } ring_state_e;

  localparam int DEF_COUNT_W     = 32;
  localparam int DEF_WINDOW_W    = 16;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the asynchronous ring output into the clock domain and flags rising edges.
// RING_COUNTER_GLITCH_FILTER_EN adds a two-sample agreement filter before edge detection.
module ring_edge_sync
  import ring_counter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic ring_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], ring_in};
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef RING_COUNTER_GLITCH_FILTER_EN
  logic filt_reg;
  logic level_reg;

  // level_reg only follows the input once two consecutive samples agree
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      filt_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      filt_reg <= sync_out;
      if (sync_out == filt_reg) level_reg <= sync_out;
    end
  end

  assign rise_pulse = sync_out & filt_reg & ~level_reg;
`else
  logic prev_reg;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= sync_out;
  end

  assign rise_pulse = sync_out & ~prev_reg;
`endif

endmodule

// File: rtl/adder_ring_counter.sv
// Counts ring-oscillator rising edges over a programmable window of clock cycles.
// RING_COUNTER_GLITCH_FILTER_EN selects the filtered edge path (one extra arm cycle).
module adder_ring_counter
  import ring_counter_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int WINDOW_W    = DEF_WINDOW_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                ring_in,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

`ifdef RING_COUNTER_GLITCH_FILTER_EN
  localparam int ARM_LEN = SYNC_STAGES + 2;
`else
  localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
  localparam int TIMER_W = max_int(WINDOW_W, $clog2(ARM_LEN + 1));

  ring_state_e         state_reg, state_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [WINDOW_W-1:0] window_reg, window_next;
  logic [COUNT_W-1:0]  count_reg, count_next;
  logic                overflow_reg, overflow_next;
  logic                rise_pulse;

  ring_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .ring_in   (ring_in),
    .rise_pulse(rise_pulse)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      window_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      window_reg   <= window_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    window_next   = window_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          // abort has no effect in IDLE beyond keeping everything cleared
          state_next    = ST_IDLE;
          count_next    = '0;
          overflow_next = 1'b0;
        end else if (start) begin
          state_next    = ST_ARM;
          window_next   = window_len;
          timer_next    = TIMER_W'(ARM_LEN - 1);
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end

      ST_ARM: begin
        if (abort) begin
          state_next    = ST_IDLE;
          count_next    = '0;
          overflow_next = 1'b0;
        end else if (timer_reg == '0) begin
          state_next = (window_reg == '0) ? ST_DONE : ST_COUNT;
          timer_next = TIMER_W'(window_reg) - TIMER_W'(1);
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end

      ST_COUNT: begin
        if (abort) begin
          state_next    = ST_IDLE;
          count_next    = '0;
          overflow_next = 1'b0;
        end else begin
          // saturate rather than wrap; an edge arriving at all-ones flags overflow
          if (rise_pulse) begin
            if (&count_reg) overflow_next = 1'b1;
            else            count_next    = count_reg + COUNT_W'(1);
          end
          if (timer_reg == '0) state_next = ST_DONE;
          else                 timer_next = timer_reg - TIMER_W'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg == ST_ARM) || (state_reg == ST_COUNT);
  assign ring_en  = busy;
  assign done     = (state_reg == ST_DONE);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_adder_ring_counter.sv
// Directed and randomized measurements checked against an edge-timestamp model of the counter.
module tb_adder_ring_counter;

  localparam int S = 2;
`ifdef RING_COUNTER_GLITCH_FILTER_EN
  localparam int  ARM = S + 2;
  localparam int  LAT = S + 1;
  localparam bit  FILT = 1'b1;
`else
  localparam int  ARM = S + 1;
  localparam int  LAT = S;
  localparam bit  FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] window_len;
  logic        ring_in;
  logic        ring_en, busy, done, overflow;
  logic [31:0] count;
  logic        ring_en4, busy4, done4, overflow4;
  logic [3:0]  count4;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  int     ring_mode = 0;
  int     hp = 4;
  longint rise_t[$];
  int     rise_w[$];

  adder_ring_counter #(.COUNT_W(32), .WINDOW_W(16), .SYNC_STAGES(S)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .ring_in(ring_in), .ring_en(ring_en), .busy(busy), .done(done), .count(count),
    .overflow(overflow)
  );

  adder_ring_counter #(.COUNT_W(4), .WINDOW_W(16), .SYNC_STAGES(S)) dut4 (
    .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .ring_in(ring_in), .ring_en(ring_en4), .busy(busy4), .done(done4), .count(count4),
    .overflow(overflow4)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ring stimulus changes on the falling edge; each rise is logged with the first edge that samples it
  initial begin
    int ph;
    ph = 0;
    ring_in = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      case (ring_mode)
        1: if (ph % hp == 0) begin
             ring_in = ~ring_in;
             if (ring_in) begin rise_t.push_back(cyc + 1); rise_w.push_back(hp); end
           end
        2: begin
             ring_in = (ph % 8 == 0);
             if (ring_in) begin rise_t.push_back(cyc + 1); rise_w.push_back(1); end
           end
        default: ring_in = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // number of rising edges whose increment lands on one of the window's counting edges
  function automatic longint model_edges(input longint n0, input int w);
    longint n;
    longint lo, hi;
    n  = 0;
    lo = n0 + ARM + 1;
    hi = n0 + ARM + w;
    foreach (rise_t[i]) begin
      if (rise_t[i] + LAT >= lo && rise_t[i] + LAT <= hi && (!FILT || rise_w[i] >= 2)) n++;
    end
    return n;
  endfunction

  task automatic do_start(input int w, output longint n0);
    window_len = 16'(w);
    start = 1'b1;
    n0 = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (!done && k < budget) begin tick(); k++; end
    ok = done;
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_ring(input int mode, input int half);
    ring_mode = 0;
    repeat (6) tick();
    hp = half;
    ring_mode = mode;
  endtask

  task automatic measure(input string tag, input int w, output longint n_edges);
    longint n0;
    bit     ok;
    do_start(w, n0);
    if (w > 0) check({tag, "_busy"}, busy, 1);
    wait_done(tag, w + ARM + 20, ok);
    n_edges = model_edges(n0, w);
    if (ok) begin
      check({tag, "_done_cycle"}, cyc, n0 + ARM + w);
      check({tag, "_count"}, count, n_edges);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_ring_en"}, ring_en, 0);
    end
    $display("[TB] %s window=%0d count=%0d model=%0d", tag, w, count, n_edges);
  endtask

  initial begin
    longint n, n0;
    bit     ok;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; window_len = '0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_ring_en", ring_en, 0);
    check("reset_done", done, 0);
    check("reset_count", count, 0);
    check("reset_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    set_ring(1, 4);
    measure("toggle4_w80", 80, n);
    check("toggle4_w80_ten", count, 10);
    repeat (5) tick();
    check("done_held", done, 1);
    check("count_held", count, 10);

    do_start(0, n0);
    repeat (ARM - 1) tick();
    check("w0_done_early", done, 0);
    tick();
    check("w0_done", done, 1);
    check("w0_count", count, 0);
    check("w0_cycle", cyc, n0 + ARM);

    set_ring(1, 2);
    do_start(100, n0);
    wait_done("sat", 100 + ARM + 20, ok);
    n = model_edges(n0, 100);
    check("sat_count4", count4, (n > 15) ? 15 : n);
    check("sat_ovf4", overflow4, (n > 15) ? 1 : 0);
    check("sat_count32", count, n);
    $display("[TB] sat count4=%0d ovf4=%0d model=%0d", count4, overflow4, n);
    do_start(20, n0);
    check("restart_clr_count4", count4, 0);
    check("restart_clr_ovf4", overflow4, 0);
    wait_done("restart", 20 + ARM + 20, ok);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_clr", done, 0);
    check("abort_done_count", count, 0);

    set_ring(1, 3);
    do_start(60, n0);
    repeat (ARM + 10) tick();
    check("abort_pre_count_nz", (count != 0) ? 1 : 0, (model_edges(n0, 10) != 0) ? 1 : 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_ring_en", ring_en, 0);
    check("abort_done", done, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    $display("[TB] abort busy=%0d count=%0d", busy, count);

    do_start(80, n0);
    repeat (ARM + 20) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ring_en", ring_en, 0);
    check("async_rst_count", count, 0);
    check("async_rst_done", done, 0);
    #3 rst_n = 1'b1;
    repeat (10) tick();
    check("no_resume_busy", busy, 0);
    $display("[TB] async reset busy=%0d count=%0d", busy, count);

    set_ring(2, 1);
    measure("glitch_w64", 64, n);
    if (FILT) check("glitch_filtered", count, 0);
    else      check("glitch_ge7", (count >= 7) ? 1 : 0, 1);

    for (int r = 0; r < 5; r++) begin
      int w, h;
      h = int'($urandom_range(2, 6));
      w = int'($urandom_range(1, 120));
      set_ring(1, h);
      repeat ($urandom_range(0, 7)) tick();
      measure($sformatf("rand%0d_hp%0d", r, h), w, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
